// File: rtl/tcp_tx_len_gate_pkg.sv
// Shared types and helpers for the TCP TX length gate.
package tcp_tx_len_gate_pkg;

    localparam int TCP_LEN_BITS      = 16;
    localparam int AXI_NET_BITS      = 512;
    localparam int AXI_KEEP_BITS     = AXI_NET_BITS / 8;
    localparam int TCP_BEAT_LOG_BITS = 6;
    localparam int TCP_BEATS_BITS    = TCP_LEN_BITS - 5;

    typedef logic [TCP_BEATS_BITS-1:0]      beats_t;
    typedef logic signed [TCP_BEATS_BITS:0] crd_t;

    typedef struct packed {
        logic [15:0]             sid;
        logic [TCP_LEN_BITS-1:0] len;
    } tcp_tx_meta_t;

    // Queue entry: meta plus its precomputed beat count.
    typedef struct packed {
        tcp_tx_meta_t meta;
        beats_t       n_beats;
    } meta_ent_t;

    typedef struct packed {
        logic [AXI_NET_BITS-1:0]  data;
        logic [AXI_KEEP_BITS-1:0] keep;
        logic                     last;
    } beat_t;

    typedef enum logic       {I_IDLE, I_DATA}         ingest_state_t;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_SEND} release_state_t;

    // ceil(len / 64); zero for a zero-length transfer.
    function automatic beats_t tcp_n_beats(input logic [TCP_LEN_BITS-1:0] len);
        logic [TCP_LEN_BITS:0] sum;
        sum = {1'b0, len} + (TCP_LEN_BITS+1)'(2**TCP_BEAT_LOG_BITS - 1);
        return beats_t'(sum >> TCP_BEAT_LOG_BITS);
    endfunction

endpackage

// File: rtl/tcp_tx_len_gate_if.sv
// Valid/ready stream bundle used for both the meta and payload channels.
// Meta instances carry the packed meta in data and leave keep/last idle.
interface tcp_tx_len_gate_if
    import tcp_tx_len_gate_pkg::*;
#(
    parameter int DATA_BITS = AXI_NET_BITS,
    parameter int KEEP_BITS = AXI_KEEP_BITS
);
    logic                 valid;
    logic                 ready;
    logic [DATA_BITS-1:0] data;
    logic [KEEP_BITS-1:0] keep;
    logic                 last;

    modport m (output valid, data, keep, last, input ready);
    modport s (input valid, data, keep, last, output ready);
endinterface

// File: rtl/tcp_tx_len_gate_queue.sv
// Plain synchronous FIFO; reset flushes the pointers, storage is not cleared.
module tcp_tx_len_gate_queue #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wp, rp;

    assign empty = (wp == rp);
    assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign dout  = mem[rp[AW-1:0]];

    // Pointer update; the extra MSB tells full from empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push && !full) wp <= wp + (AW+1)'(1);
            if (pop && !empty) rp <= rp + (AW+1)'(1);
        end
    end

    // Storage write.
    always_ff @(posedge clk) begin
        if (push && !full) mem[wp[AW-1:0]] <= din;
    end
endmodule

// File: rtl/tcp_tx_len_trim.sv
// Forces tlast from the length-derived beat position, trims the final
// beat's tkeep to the residual byte count and flags producer tlast errors.
module tcp_tx_len_trim
    import tcp_tx_len_gate_pkg::*;
(
    input  logic                         final_beat,
    input  logic [TCP_BEAT_LOG_BITS-1:0] len_lo,
    input  logic [AXI_KEEP_BITS-1:0]     keep_in,
    input  logic                         last_in,
    output logic [AXI_KEEP_BITS-1:0]     keep_out,
    output logic                         last_out,
    output logic                         mismatch
);
    logic [AXI_KEEP_BITS-1:0] mask;

    // len_lo == 0 means the final beat is completely full.
    always_comb begin
        mask = '1;
        if (len_lo != '0) mask = (AXI_KEEP_BITS'(1) << len_lo) - AXI_KEEP_BITS'(1);
        keep_out = final_beat ? (keep_in & mask) : keep_in;
        last_out = final_beat;
        mismatch = (last_in != final_beat);
    end
endmodule

// File: rtl/tcp_tx_len_gate.sv
// Per-region TX staging: buffers payload and holds each meta back until
// enough of its payload is resident, so the arbiter never stalls mid-burst.
module tcp_tx_len_gate
    import tcp_tx_len_gate_pkg::*;
#(
    parameter int DATA_DEPTH = 64,
    parameter int META_DEPTH = 4
) (
    input  logic        aclk,
    input  logic        areset,
    tcp_tx_len_gate_if.s s_tx_meta,
    tcp_tx_len_gate_if.m m_tx_meta,
    tcp_tx_len_gate_if.s s_axis_tx,
    tcp_tx_len_gate_if.m m_axis_tx,
    output logic [15:0] err_cnt
);
    localparam beats_t DEPTH_BEATS = beats_t'(DATA_DEPTH);
    localparam beats_t ONE_BEAT    = beats_t'(1);

    logic alive;

    tcp_tx_meta_t in_meta;
    meta_ent_t    in_ent, iq_head, rq_head;
    logic         meta_push, iq_full, iq_empty, iq_pop, rq_full, rq_empty, rq_pop;

    ingest_state_t                i_state, i_next;
    beats_t                       cur_n, cnt;
    logic [TCP_BEAT_LOG_BITS-1:0] cur_lo;
    logic                         final_beat, wr, mismatch;
    logic [AXI_KEEP_BITS-1:0]     trim_keep;
    logic                         trim_last;
    beat_t                        wr_beat, rd_beat;
    logic                         pf_full, pf_empty, pf_pop;

    release_state_t r_state, r_next;
    meta_ent_t      r_ent;
    crd_t           crd, crd_nxt;
    beats_t         thr;
    logic           rel;

    // Hold ready low through reset and the first cycle after it.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) alive <= 1'b0;
        else        alive <= 1'b1;
    end

    // ---------------- meta intake ----------------
    assign in_meta         = s_tx_meta.data;
    assign in_ent          = '{meta: in_meta, n_beats: tcp_n_beats(in_meta.len)};
    assign s_tx_meta.ready = alive && !iq_full && !rq_full;
    assign meta_push       = s_tx_meta.valid && s_tx_meta.ready;

    tcp_tx_len_gate_queue #(.W($bits(meta_ent_t)), .DEPTH(META_DEPTH)) u_iq (
        .clk(aclk), .rst(areset), .push(meta_push), .din(in_ent),
        .pop(iq_pop), .dout(iq_head), .full(iq_full), .empty(iq_empty)
    );

    tcp_tx_len_gate_queue #(.W($bits(meta_ent_t)), .DEPTH(META_DEPTH)) u_rq (
        .clk(aclk), .rst(areset), .push(meta_push), .din(in_ent),
        .pop(rq_pop), .dout(rq_head), .full(rq_full), .empty(rq_empty)
    );

    // ---------------- payload ingest ----------------
    assign final_beat = (cnt == cur_n - ONE_BEAT);
    assign wr         = (i_state == I_DATA) && s_axis_tx.valid && !pf_full;

    // Ingest next-state and producer ready.
    always_comb begin
        i_next          = i_state;
        iq_pop          = 1'b0;
        s_axis_tx.ready = 1'b0;
        case (i_state)
            I_IDLE: begin
                if (!iq_empty) begin
                    iq_pop = 1'b1;
                    if (iq_head.n_beats != '0) i_next = I_DATA;
                end
            end
            I_DATA: begin
                s_axis_tx.ready = !pf_full;
                if (wr && final_beat) i_next = I_IDLE;
            end
            default: i_next = I_IDLE;
        endcase
    end

    // Ingest state, latched transfer length and beat counter.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            i_state <= I_IDLE;
            cur_n   <= '0;
            cur_lo  <= '0;
            cnt     <= '0;
        end else begin
            i_state <= i_next;
            if (i_state == I_IDLE && !iq_empty) begin
                cur_n  <= iq_head.n_beats;
                cur_lo <= iq_head.meta.len[TCP_BEAT_LOG_BITS-1:0];
                cnt    <= '0;
            end else if (wr) begin
                cnt <= cnt + ONE_BEAT;
            end
        end
    end

    tcp_tx_len_trim u_trim (
        .final_beat(final_beat), .len_lo(cur_lo),
        .keep_in(s_axis_tx.keep), .last_in(s_axis_tx.last),
        .keep_out(trim_keep), .last_out(trim_last), .mismatch(mismatch)
    );

    assign wr_beat = '{data: s_axis_tx.data, keep: trim_keep, last: trim_last};

    // Saturating count of producer tlast disagreements with len.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset)                                 err_cnt <= '0;
        else if (wr && mismatch && err_cnt != '1)   err_cnt <= err_cnt + 16'd1;
    end

    tcp_tx_len_gate_queue #(.W($bits(beat_t)), .DEPTH(DATA_DEPTH)) u_pf (
        .clk(aclk), .rst(areset), .push(wr), .din(wr_beat),
        .pop(pf_pop), .dout(rd_beat), .full(pf_full), .empty(pf_empty)
    );

    // Payload may run ahead of its meta; the arbiter only pulls after the meta.
    assign m_axis_tx.valid = !pf_empty;
    assign m_axis_tx.data  = rd_beat.data;
    assign m_axis_tx.keep  = rd_beat.keep;
    assign m_axis_tx.last  = rd_beat.last;
    assign pf_pop          = m_axis_tx.valid && m_axis_tx.ready;

    // ---------------- meta release ----------------
    // Larger-than-FIFO payloads release at FIFO depth to avoid deadlock.
    assign thr     = (r_ent.n_beats > DEPTH_BEATS) ? DEPTH_BEATS : r_ent.n_beats;
    assign rel     = (r_state == R_SEND) && m_tx_meta.ready;
    assign crd_nxt = crd + crd_t'(wr) - (rel ? crd_t'(r_ent.n_beats) : '0);

    assign m_tx_meta.data = r_ent.meta;
    assign m_tx_meta.keep = '0;
    assign m_tx_meta.last = 1'b0;

    // Release next-state; the wait test looks at post-update credit so the
    // meta goes out the cycle after the threshold beat lands.
    always_comb begin
        r_next          = r_state;
        rq_pop          = 1'b0;
        m_tx_meta.valid = 1'b0;
        case (r_state)
            R_IDLE: if (!rq_empty) r_next = R_WAIT;
            R_WAIT: if (crd_nxt >= crd_t'(thr)) r_next = R_SEND;
            R_SEND: begin
                m_tx_meta.valid = 1'b1;
                if (m_tx_meta.ready) begin
                    rq_pop = 1'b1;
                    r_next = R_IDLE;
                end
            end
            default: r_next = R_IDLE;
        endcase
    end

    // Release state, held meta and beat credit.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state <= R_IDLE;
            r_ent   <= '0;
            crd     <= '0;
        end else begin
            r_state <= r_next;
            crd     <= crd_nxt;
            if (r_state == R_IDLE && !rq_empty) r_ent <= rq_head;
        end
    end
endmodule

// File: tb/tb_tcp_tx_len_gate.sv
// Directed bench for tcp_tx_len_gate with a 4-beat payload FIFO.
module tb_tcp_tx_len_gate;
    import tcp_tx_len_gate_pkg::*;

    logic        aclk = 1'b0;
    logic        areset;
    logic [15:0] err_cnt;

    always #5 aclk = ~aclk;

    tcp_tx_len_gate_if #(.DATA_BITS($bits(tcp_tx_meta_t)), .KEEP_BITS(1)) im();
    tcp_tx_len_gate_if #(.DATA_BITS($bits(tcp_tx_meta_t)), .KEEP_BITS(1)) om();
    tcp_tx_len_gate_if ia();
    tcp_tx_len_gate_if oa();

    tcp_tx_len_gate #(.DATA_DEPTH(4), .META_DEPTH(4)) dut (
        .aclk(aclk), .areset(areset),
        .s_tx_meta(im), .m_tx_meta(om),
        .s_axis_tx(ia), .m_axis_tx(oa),
        .err_cnt(err_cnt)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    beat_t        out_q[$];
    tcp_tx_meta_t mo_q[$];
    int           mo_cyc[$];
    int           wr_cyc[$];
    int           mi_cyc[$];
    bit           rdy_seen;

    always @(posedge aclk) cyc <= cyc + 1;

    // Record every handshake mid-cycle, away from the active edge.
    always @(negedge aclk) begin
        beat_t b;
        if (oa.valid && oa.ready) begin
            b.data = oa.data; b.keep = oa.keep; b.last = oa.last;
            out_q.push_back(b);
        end
        if (om.valid && om.ready) begin
            mo_q.push_back(om.data);
            mo_cyc.push_back(cyc);
        end
        if (ia.valid && ia.ready) wr_cyc.push_back(cyc);
        if (im.valid && im.ready) mi_cyc.push_back(cyc);
        if (ia.ready) rdy_seen = 1'b1;
    end

    typedef struct {
        logic [15:0] len;
        int          nb;
        logic [15:0] last_in;
        logic [63:0] keep_fin;
        logic [15:0] last_exp;
        int          err_exp;
        int          thr_idx;
    } vec_t;

    vec_t vt[6];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    task automatic clear_mon();
        out_q.delete(); mo_q.delete(); mo_cyc.delete();
        wr_cyc.delete(); mi_cyc.delete(); rdy_seen = 1'b0;
    endtask

    task automatic send_meta(input logic [15:0] sid, input logic [15:0] len);
        int t = 0;
        im.valid = 1'b1;
        im.data  = {sid, len};
        @(negedge aclk);
        while (!im.ready && t < 50) begin @(negedge aclk); t++; end
        if (!im.ready) begin
            total++; bad++;
            $display("FAIL meta_in_timeout: sid=%0d not accepted", sid);
        end
        @(posedge aclk); #1;
        im.valid = 1'b0;
    endtask

    task automatic send_beat(input logic [511:0] d, input logic [63:0] k, input logic l);
        int t = 0;
        ia.valid = 1'b1; ia.data = d; ia.keep = k; ia.last = l;
        @(negedge aclk);
        while (!ia.ready && t < 100) begin @(negedge aclk); t++; end
        if (!ia.ready) begin
            total++; bad++;
            $display("FAIL beat_in_timeout: tready never came");
        end
        @(posedge aclk); #1;
        ia.valid = 1'b0;
    endtask

    initial begin
        logic [15:0] got_last;
        logic [63:0] lk;
        bit          data_ok, keep_ok;
        int          d;

        vt[0] = '{16'd200, 4,  16'h0008, 64'h0000_0000_0000_00FF, 16'h0008, 0, 3};
        vt[1] = '{16'd128, 2,  16'h0001, 64'hFFFF_FFFF_FFFF_FFFF, 16'h0002, 2, 1};
        vt[2] = '{16'd64,  1,  16'h0001, 64'hFFFF_FFFF_FFFF_FFFF, 16'h0001, 2, 0};
        vt[3] = '{16'd1,   1,  16'h0000, 64'h0000_0000_0000_0001, 16'h0001, 3, 0};
        vt[4] = '{16'd100, 2,  16'h0002, 64'h0000_000F_FFFF_FFFF, 16'h0002, 3, 1};
        vt[5] = '{16'd640, 10, 16'h0200, 64'hFFFF_FFFF_FFFF_FFFF, 16'h0200, 3, 3};

        areset = 1'b1;
        im.valid = 1'b0; im.data = '0; im.keep = '0; im.last = 1'b0;
        ia.valid = 1'b0; ia.data = '0; ia.keep = '0; ia.last = 1'b0;
        om.ready = 1'b1; oa.ready = 1'b1;
        tick(3);
        chk("rst_m_meta_valid", om.valid, 0);
        chk("rst_m_axis_valid", oa.valid, 0);
        chk("rst_s_meta_ready", im.ready, 0);
        chk("rst_s_axis_ready", ia.ready, 0);
        chk("rst_err_cnt", err_cnt, 0);
        areset = 1'b0;
        tick(2);

        // Single-transfer vectors.
        for (int v = 0; v < 6; v++) begin
            clear_mon();
            send_meta(16'(v), vt[v].len);
            for (int b = 0; b < vt[v].nb; b++)
                send_beat(512'(v * 256 + b), 64'hFFFF_FFFF_FFFF_FFFF, vt[v].last_in[b]);
            tick(20);
            got_last = '0; data_ok = 1'b1; keep_ok = 1'b1;
            foreach (out_q[i]) begin
                if (i < 16) got_last[i] = out_q[i].last;
                if (out_q[i].data !== 512'(v * 256 + i)) data_ok = 1'b0;
                if (i != vt[v].nb - 1 && out_q[i].keep !== 64'hFFFF_FFFF_FFFF_FFFF) keep_ok = 1'b0;
            end
            lk = (out_q.size() > 0) ? out_q[out_q.size()-1].keep : 64'd0;
            chk($sformatf("v%0d_beats", v), out_q.size(), vt[v].nb);
            chk($sformatf("v%0d_tlast", v), got_last, vt[v].last_exp);
            chk($sformatf("v%0d_fin_keep", v), lk, vt[v].keep_fin);
            chk($sformatf("v%0d_mid_keep_ok", v), keep_ok, 1);
            chk($sformatf("v%0d_data_ok", v), data_ok, 1);
            chk($sformatf("v%0d_err_cnt", v), err_cnt, vt[v].err_exp);
            chk($sformatf("v%0d_meta_cnt", v), mo_q.size(), 1);
            chk($sformatf("v%0d_meta_len", v), (mo_q.size() > 0) ? mo_q[0].len : 16'hDEAD, vt[v].len);
            d = (mo_q.size() > 0 && wr_cyc.size() > vt[v].thr_idx)
                ? mo_cyc[0] - wr_cyc[vt[v].thr_idx] : -1;
            chk($sformatf("v%0d_meta_lat", v), d, 1);
            if (v == 5) chk("v5_crd_zero", dut.crd, 0);
        end

        // Zero-length meta passes with no payload.
        clear_mon();
        send_meta(16'h20, 16'd0);
        tick(10);
        chk("z_meta_cnt", mo_q.size(), 1);
        d = (mo_q.size() > 0 && mi_cyc.size() > 0) ? mo_cyc[0] - mi_cyc[0] : 99;
        chk("z_meta_within_3", (d >= 1 && d <= 3), 1);
        chk("z_no_tready", rdy_seen, 0);
        chk("z_no_beats", out_q.size(), 0);

        // Back-to-back one-beat metas, data withheld then released one by one.
        clear_mon();
        send_meta(16'd30, 16'd64);
        send_meta(16'd31, 16'd64);
        send_meta(16'd32, 16'd64);
        tick(10);
        chk("bb_held", mo_q.size(), 0);
        for (int k = 0; k < 3; k++) begin
            send_beat(512'(900 + k), 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
            tick(4);
            chk($sformatf("bb%0d_meta_cnt", k), mo_q.size(), k + 1);
            chk($sformatf("bb%0d_sid", k), (mo_q.size() > k) ? mo_q[k].sid : 16'hDEAD, 30 + k);
            chk($sformatf("bb%0d_after_beat", k),
                (mo_q.size() > k && wr_cyc.size() > k) ? (mo_cyc[k] > wr_cyc[k]) : 1'b0, 1);
        end
        chk("bb_beats", out_q.size(), 3);

        // Reset while beats are buffered and the meta is waiting.
        clear_mon();
        oa.ready = 1'b0;
        send_meta(16'd40, 16'd256);
        for (int b = 0; b < 3; b++) send_beat(512'(700 + b), 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        tick(3);
        chk("rs_pre_axis_valid", oa.valid, 1);
        chk("rs_pre_meta_valid", om.valid, 0);
        #2 areset = 1'b1;
        #1;
        chk("rs_axis_valid", oa.valid, 0);
        chk("rs_meta_valid", om.valid, 0);
        chk("rs_meta_ready", im.ready, 0);
        chk("rs_axis_ready", ia.ready, 0);
        chk("rs_err_cnt", err_cnt, 0);
        @(posedge aclk); #1;
        areset = 1'b0;
        oa.ready = 1'b1;
        clear_mon();
        send_meta(16'd41, 16'd64);
        send_beat(512'hABCD, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        tick(10);
        chk("rs_post_beats", out_q.size(), 1);
        chk("rs_post_data", (out_q.size() > 0) ? out_q[0].data[63:0] : 64'hDEAD, 64'hABCD);
        chk("rs_post_meta_cnt", mo_q.size(), 1);
        chk("rs_post_sid", (mo_q.size() > 0) ? mo_q[0].sid : 16'hDEAD, 41);
        chk("rs_post_err", err_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
